// File: rtl/nasti_write_arbiter_if.sv
// nasti_write_arbiter_if: requester-side and slave-side write handshakes plus route selects for the arbiter.
interface nasti_write_arbiter_if #(
  parameter int NREQ      = 4,
  parameter int SEL_WIDTH = 2
);
  logic [NREQ-1:0]      req_aw_valid, req_aw_ready;
  logic [NREQ-1:0]      req_w_valid, req_w_last, req_w_ready;
  logic [NREQ-1:0]      req_b_valid, req_b_ready;
  logic                 m_aw_valid, m_aw_ready;
  logic                 m_w_valid, m_w_last, m_w_ready;
  logic                 m_b_valid, m_b_ready;
  logic [SEL_WIDTH-1:0] aw_sel, b_sel;
  logic                 busy, wdog_err;
  modport master (
    input  req_aw_valid, req_w_valid, req_w_last, req_b_ready, m_aw_ready, m_w_ready, m_b_valid,
    output req_aw_ready, req_w_ready, req_b_valid, m_aw_valid, m_w_valid, m_w_last, m_b_ready,
    output aw_sel, b_sel, busy, wdog_err
  );
  modport slave (
    output req_aw_valid, req_w_valid, req_w_last, req_b_ready, m_aw_ready, m_w_ready, m_b_valid,
    input  req_aw_ready, req_w_ready, req_b_valid, m_aw_valid, m_w_valid, m_w_last, m_b_ready,
    input  aw_sel, b_sel, busy, wdog_err
  );
endinterface

// File: rtl/nasti_write_arbiter.sv
// nasti_write_arbiter: round-robin AW/W arbiter with an in-order B-route FIFO.
// Define NASTI_WRITE_ARBITER_WDOG_EN to enable the sticky W-stall watchdog (wdog_err).
module nasti_write_arbiter #(
  parameter int NREQ        = 4,
  parameter int SEL_WIDTH   = 2,
  parameter int DEPTH       = 4,
  parameter int WDOG_CYCLES = 256
) (
  input logic clk,
  input logic rst,
  nasti_write_arbiter_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  state_t               state;
  logic [SEL_WIDTH-1:0] sel, last, win, head;
  logic [SEL_WIDTH-1:0] fifo [DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [AW:0]          count;
  logic [NREQ-1:0]      sel_oh, head_oh;
  logic                 found, in_addr, in_data, ne, full, aw_hs, w_hs, b_hs;
  always_comb begin
    win = '0;
    found = 1'b0;
    for (int i = 1; i <= NREQ; i++)
      if (!found && |(bus.req_aw_valid & (NREQ'(1) << ((int'(last) + i) % NREQ)))) begin
        win = SEL_WIDTH'((int'(last) + i) % NREQ);
        found = 1'b1;
      end
  end
  // all outputs are gated by rst so a reset cycle can never complete a handshake
  assign sel_oh           = NREQ'(1) << sel;
  assign head             = fifo[rd_ptr];
  assign head_oh          = NREQ'(1) << head;
  assign in_addr          = !rst && state == ADDR;
  assign in_data          = !rst && state == DATA;
  assign ne               = !rst && count != '0;
  assign full             = count == (AW+1)'(DEPTH);
  assign bus.m_aw_valid   = in_addr && |(bus.req_aw_valid & sel_oh);
  assign bus.req_aw_ready = in_addr && bus.m_aw_ready ? sel_oh : '0;
  assign bus.m_w_valid    = in_data && |(bus.req_w_valid & sel_oh);
  assign bus.m_w_last     = in_data && |(bus.req_w_last & sel_oh);
  assign bus.req_w_ready  = in_data && bus.m_w_ready ? sel_oh : '0;
  assign bus.b_sel        = ne ? head : '0;
  assign bus.req_b_valid  = ne && bus.m_b_valid ? head_oh : '0;
  assign bus.m_b_ready    = ne && |(bus.req_b_ready & head_oh);
  assign bus.aw_sel       = rst ? '0 : sel;
  assign bus.busy         = !rst && (state != IDLE || count != '0);
  assign aw_hs            = bus.m_aw_valid && bus.m_aw_ready;
  assign w_hs             = bus.m_w_valid && bus.m_w_ready;
  assign b_hs             = ne && bus.m_b_valid && bus.m_b_ready;
  always_ff @(posedge clk)
    if (rst) begin
      state  <= IDLE;
      sel    <= '0;
      last   <= SEL_WIDTH'(NREQ - 1);
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      case (state)
        IDLE: if (found && !full) begin
          sel   <= win;
          state <= ADDR;
        end
        ADDR: if (aw_hs) state <= DATA;
        DATA: if (w_hs && bus.m_w_last) begin
          state <= IDLE;
          last  <= sel;
        end
        default: state <= IDLE;
      endcase
      if (aw_hs) wr_ptr <= wr_ptr + 1'b1;
      if (b_hs) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(aw_hs) - (AW+1)'(b_hs);
    end
  always_ff @(posedge clk)
    if (aw_hs) fifo[wr_ptr] <= sel;
`ifdef NASTI_WRITE_ARBITER_WDOG_EN
  localparam int CW = $clog2(WDOG_CYCLES + 1);
  logic [CW-1:0] wdog_cnt;
  logic          wdog_q, stall;
  assign stall        = in_data && !w_hs;
  assign bus.wdog_err = !rst && wdog_q;
  always_ff @(posedge clk)
    if (rst) begin
      wdog_cnt <= '0;
      wdog_q   <= 1'b0;
    end else begin
      wdog_cnt <= !stall ? '0 : wdog_cnt == CW'(WDOG_CYCLES) ? wdog_cnt : wdog_cnt + 1'b1;
      if (stall && wdog_cnt == CW'(WDOG_CYCLES - 1)) wdog_q <= 1'b1;
    end
`else
  assign bus.wdog_err = 1'b0;
`endif
endmodule

// File: tb/tb_nasti_write_arbiter.sv
// tb_nasti_write_arbiter: directed checks of grant order, W routing, B-route FIFO, watchdog and reset.
module tb_nasti_write_arbiter;
  localparam int NREQ = 4, SW = 2, DEPTH = 4, WDOG = 8;
`ifdef NASTI_WRITE_ARBITER_WDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  int ncmp = 0, nfail = 0, beats;
  int order [4] = '{1, 3, 0, 2};
  nasti_write_arbiter_if #(.NREQ(NREQ), .SEL_WIDTH(SW)) bus ();
  nasti_write_arbiter #(.NREQ(NREQ), .SEL_WIDTH(SW), .DEPTH(DEPTH), .WDOG_CYCLES(WDOG)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic zeros(input string tag);
    chk(tag, {bus.req_aw_ready, bus.req_w_ready, bus.req_b_valid, bus.m_aw_valid, bus.m_w_valid,
              bus.m_w_last, bus.m_b_ready, bus.aw_sel, bus.b_sel, bus.busy, bus.wdog_err}, 32'd0);
  endtask
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic do_write(input int r);
    bus.req_aw_valid = NREQ'(1) << r;
    bus.req_w_valid  = NREQ'(1) << r;
    bus.req_w_last   = NREQ'(1) << r;
    bus.m_aw_ready   = 1'b1;
    bus.m_w_ready    = 1'b1;
    tick();
    chk("wr_sel", bus.aw_sel, r);
    tick();
    bus.req_aw_valid = '0;
    tick();
    bus.req_w_valid = '0;
    bus.req_w_last  = '0;
  endtask
  initial begin
    bus.req_aw_valid = 4'b1111;
    bus.req_w_valid  = 4'b1111;
    bus.req_w_last   = 4'b1111;
    bus.req_b_ready  = 4'b1111;
    bus.m_aw_ready   = 1'b1;
    bus.m_w_ready    = 1'b1;
    bus.m_b_valid    = 1'b1;
    repeat (2) tick();
    #1;
    zeros("in_rst");
    rst = 1'b0;
    #1;
    zeros("post_rst");
    for (int k = 0; k < 5; k++) begin
      chk("t1_idle_awv", bus.m_aw_valid, 0);
      tick();
      chk("t1_sel", bus.aw_sel, k % 4);
      chk("t1_awv", bus.m_aw_valid, 1);
      chk("t1_awr", bus.req_aw_ready, 1 << (k % 4));
      tick();
      chk("t1_wr", bus.req_w_ready, 1 << (k % 4));
      chk("t1_bv", bus.req_b_valid, 1 << (k % 4));
      tick();
    end
    bus.req_aw_valid = 4'b0100;
    bus.req_w_valid  = 4'b1111;
    bus.req_w_last   = 4'b1011;
    bus.m_b_valid    = 1'b0;
    bus.req_b_ready  = '0;
    #1;
    chk("t2_hold_wr", bus.req_w_ready, 0);
    chk("t2_hold_wv", bus.m_w_valid, 0);
    tick();
    chk("t2_sel", bus.aw_sel, 2);
    tick();
    bus.req_aw_valid = '0;
    beats = 0;
    for (int c = 0; c < 8; c++) begin
      bus.m_w_ready  = c[0];
      bus.req_w_last = 4'b1011 | (beats == 3 ? 4'b0100 : 4'b0000);
      #1;
      chk("t2_wr", bus.req_w_ready, c[0] ? 4'b0100 : 4'b0000);
      chk("t2_last", bus.m_w_last, beats == 3);
      if (c[0]) beats++;
      tick();
    end
    bus.m_w_ready = 1'b1;
    #1;
    chk("t2_idle_wr", bus.req_w_ready, 0);
    chk("t2_idle_wv", bus.m_w_valid, 0);
    bus.req_w_valid = '0;
    bus.req_w_last  = '0;
    bus.m_b_valid   = 1'b1;
    bus.req_b_ready = 4'b0100;
    #1;
    chk("t2_bsel", bus.b_sel, 2);
    chk("t2_bready", bus.m_b_ready, 1);
    tick();
    chk("t2_busy", bus.busy, 0);
    bus.m_b_valid   = 1'b0;
    bus.req_b_ready = '0;
    for (int i = 0; i < 4; i++) do_write(order[i]);
    bus.req_aw_valid = 4'b1111;
    #1;
    chk("t3_full_awr", bus.req_aw_ready, 0);
    tick();
    chk("t3_full_awv", bus.m_aw_valid, 0);
    chk("t3_full_busy", bus.busy, 1);
    tick();
    chk("t3_full_awv2", bus.m_aw_valid, 0);
    bus.req_aw_valid = '0;
    tick();
    bus.m_b_valid   = 1'b1;
    bus.req_b_ready = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t3_bsel", bus.b_sel, order[i]);
      chk("t3_bv", bus.req_b_valid, 1 << order[i]);
      chk("t3_bready", bus.m_b_ready, 1);
      tick();
    end
    chk("t3_empty_bv", bus.req_b_valid, 0);
    chk("t3_empty_br", bus.m_b_ready, 0);
    bus.m_b_valid = 1'b0;
    do_write(3);
    do_write(0);
    bus.req_aw_valid = 4'b0010;
    bus.req_w_valid  = 4'b0010;
    bus.req_w_last   = 4'b0010;
    tick();
    bus.m_b_valid = 1'b1;
    #1;
    chk("t4_awv", bus.m_aw_valid, 1);
    chk("t4_bsel", bus.b_sel, 3);
    chk("t4_bv", bus.req_b_valid, 4'b1000);
    tick();
    bus.m_b_valid    = 1'b0;
    bus.req_aw_valid = '0;
    #1;
    chk("t4_head", bus.b_sel, 0);
    tick();
    bus.req_w_valid = '0;
    bus.req_w_last  = '0;
    bus.m_b_valid   = 1'b1;
    #1;
    chk("t4_b0", bus.b_sel, 0);
    tick();
    chk("t4_tail", bus.b_sel, 1);
    tick();
    chk("t4_drained", bus.busy, 0);
    bus.m_b_valid   = 1'b0;
    bus.req_b_ready = '0;
    bus.req_aw_valid = 4'b0100;
    bus.req_w_valid  = 4'b0100;
    bus.req_w_last   = 4'b0100;
    bus.m_w_ready    = 1'b0;
    tick();
    tick();
    bus.req_aw_valid = '0;
    for (int k = 1; k <= 10; k++) begin
      #1;
      chk("t5_wdog", bus.wdog_err, WD && k >= 9);
      tick();
    end
    bus.m_w_ready = 1'b1;
    tick();
    chk("t5_sticky", bus.wdog_err, WD);
    chk("t5_idle_wv", bus.m_w_valid, 0);
    bus.req_aw_valid = 4'b1000;
    bus.req_w_valid  = 4'b1000;
    bus.req_w_last   = '0;
    tick();
    chk("t6_sel", bus.aw_sel, 3);
    tick();
    bus.req_aw_valid = '0;
    tick();
    rst = 1'b1;
    bus.m_b_valid   = 1'b1;
    bus.req_b_ready = 4'b1111;
    #1;
    zeros("t6_in_rst");
    tick();
    rst = 1'b0;
    bus.req_aw_valid = 4'b1111;
    bus.req_w_valid  = '0;
    #1;
    zeros("t6_after");
    tick();
    chk("t6_first", bus.aw_sel, 0);
    chk("t6_awv", bus.m_aw_valid, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
